// File: rtl/scan_encoder.sv
// Captures a multi-hot vector and presents the index of each set bit in turn
// under a valid/ready handshake, lowest-first or highest-first.
module scan_encoder #(
    parameter int N         = 16,
    parameter bit LSB_FIRST = 1'b1,
    localparam int W        = $clog2(N)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_dec,
    input  logic         i_load,
    input  logic         i_ready,
    output logic [W-1:0] o_bin,
    output logic         o_valid,
    output logic         o_last,
    output logic         o_busy,
    output logic         o_done,
    output logic [W:0]   o_count,
    output logic         o_AI
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t       state_reg, state_next;
    logic [N-1:0] pend_reg;
    logic [W:0]   count_reg;
    logic         done_reg, done_next;
    logic         load_ok;
    logic         hs;
    logic [W-1:0] sel_bin;
    logic [W:0]   pop;
    logic         single;

    // Priority select: the loop order makes the last match win.
    always_comb begin
        sel_bin = '0;
        if (LSB_FIRST) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pend_reg[i]) sel_bin = W'(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pend_reg[i]) sel_bin = W'(i);
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + (W+1)'(i_dec[i]);
        end
    end

    assign single = (pend_reg != '0) && ((pend_reg & (pend_reg - N'(1))) == '0);

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        load_ok    = 1'b0;
        hs         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_load) begin
                    load_ok = 1'b1;
                    if (|i_dec) state_next = SCAN;
                    else        done_next  = 1'b1;
                end
            end
            SCAN: begin
                if (i_ready) begin
                    hs = 1'b1;
                    if (single) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
            pend_reg  <= '0;
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            if (load_ok) begin
                pend_reg  <= i_dec;
                count_reg <= pop;
            end else if (hs) begin
                pend_reg <= pend_reg & ~(N'(1) << sel_bin);
            end
        end
    end

    assign o_valid = (state_reg == SCAN);
    assign o_busy  = (state_reg == SCAN);
    assign o_bin   = o_valid ? sel_bin : '0;
    assign o_last  = o_valid & single;
    assign o_done  = done_reg;
    assign o_count = count_reg;
    assign o_AI    = |i_dec;

endmodule
